// File: rtl/sub_bytes_iter.sv
// sub_bytes_iter: iterative AES SubBytes engine for a 128-bit state.
// LANES S-box instances (forward, plus inverse when INV_EN=1) are reused over
// 16/LANES cycles to substitute all 16 bytes of the block in place.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   in_data/in_inv valid
//   in_ready   engine can accept a block this cycle
//   in_data    128-bit state, byte i = in_data[8i+7:8i]
//   in_inv     0 = forward S-box, 1 = inverse S-box (sampled on acceptance)
//   out_valid  out_data holds a finished result
//   out_ready  downstream accepts out_data
//   out_data   substituted block, same byte order as in_data
//   busy       high while substituting
module sub_bytes_iter #(
    parameter int unsigned LANES  = 4,
    parameter int unsigned INV_EN = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    input  logic         in_inv,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
);

    localparam int unsigned NGRP = 16 / LANES;
    localparam int unsigned CW   = (NGRP > 1) ? $clog2(NGRP) : 1;

    if (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8 && LANES != 16) begin : g_bad_lanes
        $error("sub_bytes_iter: LANES must be 1, 2, 4, 8 or 16");
    end
    if (INV_EN > 1) begin : g_bad_inv_en
        $error("sub_bytes_iter: INV_EN must be 0 or 1");
    end

    // GF(2^8) multiply modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254 (maps 0 to 0 as AES requires).
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] r;
        sq = x;
        r  = 8'h01;
        for (int i = 0; i < 7; i++) begin
            sq = gf_mul(sq, sq);
            r  = gf_mul(r, sq);
        end
        return r;
    endfunction

    function automatic logic [7:0] sbox_fwd(input logic [7:0] x);
        logic [7:0] b;
        b = gf_inv(x);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]}
            ^ 8'h63;
    endfunction

    function automatic logic [7:0] sbox_inv(input logic [7:0] s);
        logic [7:0] b;
        b = {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
        return gf_inv(b);
    endfunction

    typedef enum logic [1:0] {StIdle, StSub, StDone} state_e;

    state_e          state_q, state_d;
    logic [127:0]    work_q, work_d;
    logic            mode_q, mode_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            accept;
    logic            last_grp;
    logic [7:0]      lane_in  [LANES];
    logic [7:0]      lane_out [LANES];

    assign accept   = in_valid && in_ready;
    assign last_grp = (cnt_q == CW'(NGRP - 1));

    // Bytes of the current group come straight from the work register, so the
    // S-box logic never sees in_data combinationally.
    always_comb begin
        for (int unsigned l = 0; l < LANES; l++) begin
            lane_in[l] = work_q[8 * (32'(cnt_q) * LANES + l) +: 8];
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        logic [7:0] fwd_b;
        assign fwd_b = sbox_fwd(lane_in[g]);
        if (INV_EN != 0) begin : g_inv
            logic [7:0] inv_b;
            assign inv_b       = sbox_inv(lane_in[g]);
            assign lane_out[g] = mode_q ? inv_b : fwd_b;
        end else begin : g_fwd
            assign lane_out[g] = fwd_b;
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (accept) state_d = StSub;
            StSub:   if (last_grp) state_d = StDone;
            StDone: begin
                if (out_ready) state_d = in_valid ? StSub : StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Output logic
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        unique case (state_q)
            StIdle:  in_ready = 1'b1;
            StSub:   busy = 1'b1;
            StDone: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
            end
            default: in_ready = 1'b0;
        endcase
    end

    assign out_data = work_q;

    // Datapath next state
    always_comb begin
        work_d = work_q;
        mode_d = mode_q;
        cnt_d  = cnt_q;
        if (accept) begin
            work_d = in_data;
            mode_d = (INV_EN != 0) && in_inv;
            cnt_d  = '0;
        end else if (state_q == StSub) begin
            for (int unsigned l = 0; l < LANES; l++) begin
                work_d[8 * (32'(cnt_q) * LANES + l) +: 8] = lane_out[l];
            end
            cnt_d = last_grp ? '0 : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            work_q <= '0;
            mode_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            work_q <= work_d;
            mode_q <= mode_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: tb/tb_sub_bytes_iter.sv
// Testbench for sub_bytes_iter. Three instances share all inputs:
//   0: LANES=4,  INV_EN=1   1: LANES=16, INV_EN=1   2: LANES=1, INV_EN=0
// Expected blocks come from S-box tables built with log/antilog arithmetic.
module tb_sub_bytes_iter;

    localparam int NDUT = 3;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               in_valid;
    logic               out_ready;
    logic               in_inv;
    logic [127:0]       in_data;
    logic [NDUT-1:0]    in_ready;
    logic [NDUT-1:0]    out_valid;
    logic [NDUT-1:0]    busy;
    logic [127:0]       out_data [NDUT];

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0]   sb  [256];
    logic [7:0]   isb [256];
    logic [127:0] exp_r [NDUT];

    always #5 clk = ~clk;

    sub_bytes_iter #(.LANES(4), .INV_EN(1)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready[0]),
        .in_data(in_data), .in_inv(in_inv), .out_valid(out_valid[0]),
        .out_ready(out_ready), .out_data(out_data[0]), .busy(busy[0])
    );
    sub_bytes_iter #(.LANES(16), .INV_EN(1)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready[1]),
        .in_data(in_data), .in_inv(in_inv), .out_valid(out_valid[1]),
        .out_ready(out_ready), .out_data(out_data[1]), .busy(busy[1])
    );
    sub_bytes_iter #(.LANES(1), .INV_EN(0)) u_dut1f (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready[2]),
        .in_data(in_data), .in_inv(in_inv), .out_valid(out_valid[2]),
        .out_ready(out_ready), .out_data(out_data[2]), .busy(busy[2])
    );

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    // Inverse via generator 3: inv(a) = 3^(255 - log3(a)); then the affine map.
    task automatic build_tables();
        logic [7:0] ex [256];
        int         lg [256];
        logic [7:0] x, y, s, c;
        c = 8'h63;
        x = 8'h01;
        for (int i = 0; i < 255; i++) begin
            ex[i] = x;
            lg[x] = i;
            x = x ^ xtime(x);
        end
        for (int a = 0; a < 256; a++) begin
            y = (a == 0) ? 8'h00 : ex[(255 - lg[a]) % 255];
            for (int i = 0; i < 8; i++)
                s[i] = y[i] ^ y[(i + 4) % 8] ^ y[(i + 5) % 8] ^ y[(i + 6) % 8] ^ y[(i + 7) % 8]
                       ^ c[i];
            sb[a]  = s;
            isb[s] = 8'(a);
        end
    endtask

    function automatic logic [127:0] model(input logic [127:0] d, input logic inv,
                                           input bit inv_en);
        logic [127:0] r;
        logic [7:0]   b;
        for (int i = 0; i < 16; i++) begin
            b = d[8*i +: 8];
            r[8*i +: 8] = (inv && inv_en) ? isb[b] : sb[b];
        end
        return r;
    endfunction

    function automatic int lat_of(input int k);
        return (k == 0) ? 4 : ((k == 1) ? 1 : 16);
    endfunction

    // Present a block; all instances must be ready. Leaves inputs scrambled.
    task automatic accept(input logic [127:0] d, input logic inv);
        in_data  = d;
        in_inv   = inv;
        in_valid = 1'b1;
        #1;
        check_eq("in_ready_at_accept", 128'(in_ready), 128'(3'b111));
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_inv    = 1'($urandom);
        in_data   = {$urandom, $urandom, $urandom, $urandom};
    endtask

    // Watch a bounded window after acceptance; check latency, busy span, result.
    task automatic observe(input logic [127:0] d, input logic inv);
        int first [NDUT];
        int bc    [NDUT];
        for (int k = 0; k < NDUT; k++) begin
            first[k] = -1;
            bc[k]    = 0;
            exp_r[k] = model(d, inv, k != 2);
        end
        for (int cyc = 0; cyc < 20; cyc++) begin
            for (int k = 0; k < NDUT; k++) begin
                if (busy[k]) bc[k]++;
                if (out_valid[k] && first[k] < 0) first[k] = cyc;
            end
            @(posedge clk);
            #1;
        end
        for (int k = 0; k < NDUT; k++) begin
            check_eq($sformatf("latency_dut%0d", k), 128'(first[k]), 128'(lat_of(k)));
            check_eq($sformatf("busy_cycles_dut%0d", k), 128'(bc[k]), 128'(lat_of(k)));
            check_eq($sformatf("data_dut%0d", k), out_data[k], exp_r[k]);
        end
    endtask

    task automatic send(input logic [127:0] d, input logic inv);
        accept(d, inv);
        observe(d, inv);
    endtask

    task automatic hold(input int stall);
        for (int i = 0; i < stall; i++) begin
            check_eq("hold_out_valid", 128'(out_valid), 128'(3'b111));
            check_eq("hold_in_ready", 128'(in_ready), 128'(0));
            for (int k = 0; k < NDUT; k++)
                check_eq($sformatf("hold_data_dut%0d", k), out_data[k], exp_r[k]);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        #1;
        check_eq("in_ready_done_ready", 128'(in_ready), 128'(3'b111));
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check_eq("out_valid_after_pop", 128'(out_valid), 128'(0));
        check_eq("in_ready_idle", 128'(in_ready), 128'(3'b111));
    endtask

    initial begin
        logic [127:0] blk;
        logic         inv;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_inv    = 1'b0;
        in_data   = '0;
        build_tables();

        // Reset state
        #12;
        check_eq("rst_out_valid", 128'(out_valid), 128'(0));
        check_eq("rst_busy", 128'(busy), 128'(0));
        check_eq("rst_in_ready", 128'(in_ready), 128'(3'b111));
        for (int k = 0; k < NDUT; k++)
            check_eq($sformatf("rst_data_dut%0d", k), out_data[k], 128'h0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Known FIPS-197 round vector, forward then inverse
        send(128'h193de3bea0f4e22b9ac68d2ae9f84808, 1'b0);
        check_eq("fips_fwd", out_data[0], 128'hd42711aee0bf98f1b8b45de51e415230);
        release_out();
        send(128'hd42711aee0bf98f1b8b45de51e415230, 1'b1);
        check_eq("fips_inv_l4", out_data[0], 128'h193de3bea0f4e22b9ac68d2ae9f84808);
        check_eq("fips_inv_l16", out_data[1], 128'h193de3bea0f4e22b9ac68d2ae9f84808);
        release_out();
        send(128'h0, 1'b1);
        check_eq("inv_zero", out_data[1], {16{8'h52}});
        release_out();
        // Forward-only build ignores in_inv
        send({16{8'h63}}, 1'b1);
        check_eq("fwd_only_63", out_data[2], {16{8'hfb}});
        check_eq("inv_63_l4", out_data[0], 128'h0);
        release_out();

        // Every byte value in both modes
        for (int m = 0; m < 2; m++) begin
            for (int k = 0; k < 16; k++) begin
                for (int i = 0; i < 16; i++) blk[8*i +: 8] = 8'(16 * k + i);
                send(blk, 1'(m));
                release_out();
            end
        end

        // Backpressure, then back-to-back acceptance in the DONE cycle
        send({$urandom, $urandom, $urandom, $urandom}, 1'b0);
        hold(5);
        out_ready = 1'b1;
        send({$urandom, $urandom, $urandom, $urandom}, 1'b1);
        release_out();

        // Reset during SUB: block discarded, outputs cleared at once
        accept({$urandom, $urandom, $urandom, $urandom}, 1'b0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("midrst_out_valid", 128'(out_valid), 128'(0));
        check_eq("midrst_busy", 128'(busy), 128'(0));
        check_eq("midrst_in_ready", 128'(in_ready), 128'(3'b111));
        for (int k = 0; k < NDUT; k++)
            check_eq($sformatf("midrst_data_dut%0d", k), out_data[k], 128'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send({$urandom, $urandom, $urandom, $urandom}, 1'b1);
        release_out();

        // Random blocks, random stalls, random back-to-back
        for (int n = 0; n < 40; n++) begin
            blk = {$urandom, $urandom, $urandom, $urandom};
            inv = 1'($urandom);
            send(blk, inv);
            hold($urandom_range(0, 3));
            if (n == 39 || ($urandom % 2) == 0) release_out();
            else out_ready = 1'b1;
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
